rob_core: RTL and testbench

- Circular reorder buffer between decoder/issue and the register file.
- Allocates one entry per issued instruction and captures CDB results.
- Retires the head in order, driving the register file's commit port (rob_in_en / rob_idx_in / rob_dest_in / rob_val_in).
- Answers operand queries by ROB index and raises roll_back on a mispredicted branch at commit.

---
 rtl/rob_core.sv | 152 +++++++++++++++
 tb/tb_rob_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_core.sv
// Circular reorder buffer: in-order retire, CDB capture, operand queries, branch rollback.
// Optional same-cycle CDB-to-query forwarding is enabled by defining ROB_CDB_FWD_EN.
module rob_core #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,

  input  logic                 issue_en,
  input  logic [4:0]           issue_dest,
  input  logic                 issue_is_br,
  input  logic [31:0]          issue_pred_pc,
  input  logic                 issue_ready,
  input  logic [31:0]          issue_val,
  output logic [ROB_IDX_W-1:0] alloc_idx,
  output logic                 full,

  input  logic                 cdb_en,
  input  logic [ROB_IDX_W-1:0] cdb_idx,
  input  logic [31:0]          cdb_val,
  input  logic [31:0]          cdb_next_pc,

  input  logic [ROB_IDX_W-1:0] q1_idx,
  input  logic [ROB_IDX_W-1:0] q2_idx,
  output logic                 q1_busy,
  output logic                 q2_busy,
  output logic [31:0]          q1_val,
  output logic [31:0]          q2_val,

  output logic                 commit_en,
  output logic [ROB_IDX_W-1:0] commit_idx,
  output logic [4:0]           commit_dest,
  output logic [31:0]          commit_val,

  output logic                 roll_back,
  output logic [31:0]          roll_back_pc
);

  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [ROB_IDX_W:0]   count;

  logic [ROB_SIZE-1:0]  valid_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [ROB_SIZE-1:0]  is_br_q;
  logic [31:0]          val_q     [ROB_SIZE];
  logic [31:0]          pred_pc_q [ROB_SIZE];
  logic [31:0]          next_pc_q [ROB_SIZE];
  logic [4:0]           dest_q    [ROB_SIZE];

  logic head_fire;
  logic mispredict;
  logic do_commit;
  logic do_issue;

  assign full      = (count == (ROB_IDX_W + 1)'(ROB_SIZE));
  assign alloc_idx = tail;

  // Head retires when its result is in; a wrong-path branch flushes instead of committing.
  assign head_fire  = valid_q[head] && ready_q[head];
  assign mispredict = head_fire && is_br_q[head] && (next_pc_q[head] != pred_pc_q[head]);
  assign do_commit  = head_fire && !mispredict;
  assign do_issue   = issue_en && !full && !mispredict;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid_q      <= '0;
      ready_q      <= '0;
      is_br_q      <= '0;
      commit_en    <= 1'b0;
      commit_idx   <= '0;
      commit_dest  <= '0;
      commit_val   <= '0;
      roll_back    <= 1'b0;
      roll_back_pc <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        val_q[i]     <= '0;
        pred_pc_q[i] <= '0;
        next_pc_q[i] <= '0;
        dest_q[i]    <= '0;
      end
    end else if (rdy_in) begin
      commit_en <= 1'b0;
      roll_back <= 1'b0;
      if (mispredict) begin
        valid_q      <= '0;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        roll_back    <= 1'b1;
        roll_back_pc <= next_pc_q[head];
      end else begin
        if (cdb_en) begin
          ready_q[cdb_idx]   <= 1'b1;
          val_q[cdb_idx]     <= cdb_val;
          next_pc_q[cdb_idx] <= cdb_next_pc;
        end
        // Placed after the CDB write so a fresh allocation always wins its slot.
        if (do_issue) begin
          valid_q[tail]   <= 1'b1;
          ready_q[tail]   <= issue_ready;
          val_q[tail]     <= issue_val;
          dest_q[tail]    <= issue_dest;
          is_br_q[tail]   <= issue_is_br;
          pred_pc_q[tail] <= issue_pred_pc;
          tail            <= tail + 1'b1;
        end
        if (do_commit) begin
          valid_q[head] <= 1'b0;
          commit_en     <= 1'b1;
          commit_idx    <= head;
          commit_dest   <= is_br_q[head] ? 5'd0 : dest_q[head];
          commit_val    <= val_q[head];
          head          <= head + 1'b1;
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef ROB_CDB_FWD_EN
  always_comb begin
    q1_busy = !ready_q[q1_idx];
    q1_val  = val_q[q1_idx];
    q2_busy = !ready_q[q2_idx];
    q2_val  = val_q[q2_idx];
    if (cdb_en && (cdb_idx == q1_idx)) begin
      q1_busy = 1'b0;
      q1_val  = cdb_val;
    end
    if (cdb_en && (cdb_idx == q2_idx)) begin
      q2_busy = 1'b0;
      q2_val  = cdb_val;
    end
  end
`else
  assign q1_busy = !ready_q[q1_idx];
  assign q1_val  = val_q[q1_idx];
  assign q2_busy = !ready_q[q2_idx];
  assign q2_val  = val_q[q2_idx];
`endif

endmodule

// File: tb/tb_rob_core.sv
// Directed self-checking bench for rob_core: in-order commit, full, rollback, queries, wrap, stall, reset.
module tb_rob_core;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_en;
  logic [4:0]  issue_dest;
  logic        issue_is_br;
  logic [31:0] issue_pred_pc;
  logic        issue_ready;
  logic [31:0] issue_val;
  logic [3:0]  alloc_idx;
  logic        full;
  logic        cdb_en;
  logic [3:0]  cdb_idx;
  logic [31:0] cdb_val;
  logic [31:0] cdb_next_pc;
  logic [3:0]  q1_idx;
  logic [3:0]  q2_idx;
  logic        q1_busy;
  logic        q2_busy;
  logic [31:0] q1_val;
  logic [31:0] q2_val;
  logic        commit_en;
  logic [3:0]  commit_idx;
  logic [4:0]  commit_dest;
  logic [31:0] commit_val;
  logic        roll_back;
  logic [31:0] roll_back_pc;

  int errors;
  int checks;
  int n_commits;

  rob_core #(.ROB_SIZE(16), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_dest(issue_dest), .issue_is_br(issue_is_br),
    .issue_pred_pc(issue_pred_pc), .issue_ready(issue_ready), .issue_val(issue_val),
    .alloc_idx(alloc_idx), .full(full),
    .cdb_en(cdb_en), .cdb_idx(cdb_idx), .cdb_val(cdb_val), .cdb_next_pc(cdb_next_pc),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .q1_val(q1_val), .q2_val(q2_val),
    .commit_en(commit_en), .commit_idx(commit_idx), .commit_dest(commit_dest),
    .commit_val(commit_val), .roll_back(roll_back), .roll_back_pc(roll_back_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    issue_en = 1'b0;
    cdb_en = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic apply_issue(input logic [4:0] d, input logic br, input logic [31:0] ppc,
                             input logic rdy, input logic [31:0] v);
    issue_en      = 1'b1;
    issue_dest    = d;
    issue_is_br   = br;
    issue_pred_pc = ppc;
    issue_ready   = rdy;
    issue_val     = v;
    tick();
    issue_en    = 1'b0;
    issue_is_br = 1'b0;
    issue_ready = 1'b0;
  endtask

  task automatic apply_cdb(input logic [3:0] idx, input logic [31:0] v, input logic [31:0] npc);
    cdb_en      = 1'b1;
    cdb_idx     = idx;
    cdb_val     = v;
    cdb_next_pc = npc;
    tick();
    cdb_en = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n_commits = 0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    issue_en = 1'b0;
    issue_dest = '0;
    issue_is_br = 1'b0;
    issue_pred_pc = '0;
    issue_ready = 1'b0;
    issue_val = '0;
    cdb_en = 1'b0;
    cdb_idx = '0;
    cdb_val = '0;
    cdb_next_pc = '0;
    q1_idx = '0;
    q2_idx = '0;

    // Reset state
    apply_reset();
    check_output("rst_commit_en", 32'(commit_en), 32'd0);
    check_output("rst_roll_back", 32'(roll_back), 32'd0);
    check_output("rst_commit_idx", 32'(commit_idx), 32'd0);
    check_output("rst_commit_dest", 32'(commit_dest), 32'd0);
    check_output("rst_commit_val", commit_val, 32'd0);
    check_output("rst_rb_pc", roll_back_pc, 32'd0);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_alloc", 32'(alloc_idx), 32'd0);

    // Three entries written back in reverse order retire in order
    apply_issue(5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    apply_issue(5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
    apply_issue(5'd3, 1'b0, 32'd0, 1'b0, 32'd0);
    q1_idx = 4'd0;
    #1;
    check_output("t1_alloc", 32'(alloc_idx), 32'd3);
    check_output("t1_q_busy0", 32'(q1_busy), 32'd1);
    apply_cdb(4'd2, 32'h33, 32'd0);
    apply_cdb(4'd1, 32'h22, 32'd0);
    check_output("t1_no_commit_yet", 32'(commit_en), 32'd0);
    apply_cdb(4'd0, 32'h11, 32'd0);
    check_output("t1_no_commit_cdb", 32'(commit_en), 32'd0);
    tick();
    check_output("t1_c0_en", 32'(commit_en), 32'd1);
    check_output("t1_c0_idx", 32'(commit_idx), 32'd0);
    check_output("t1_c0_dest", 32'(commit_dest), 32'd1);
    check_output("t1_c0_val", commit_val, 32'h11);
    tick();
    check_output("t1_c1_en", 32'(commit_en), 32'd1);
    check_output("t1_c1_idx", 32'(commit_idx), 32'd1);
    check_output("t1_c1_val", commit_val, 32'h22);
    tick();
    check_output("t1_c2_en", 32'(commit_en), 32'd1);
    check_output("t1_c2_idx", 32'(commit_idx), 32'd2);
    check_output("t1_c2_dest", 32'(commit_dest), 32'd3);
    check_output("t1_c2_val", commit_val, 32'h33);
    tick();
    check_output("t1_idle", 32'(commit_en), 32'd0);

    // Fill to full, ignored 17th issue, one commit frees a slot
    apply_reset();
    for (int i = 0; i < 16; i++) apply_issue(5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
    check_output("t2_full", 32'(full), 32'd1);
    check_output("t2_alloc", 32'(alloc_idx), 32'd0);
    apply_issue(5'd31, 1'b0, 32'd0, 1'b1, 32'hDEAD);
    q1_idx = 4'd0;
    #1;
    check_output("t2_full_17", 32'(full), 32'd1);
    check_output("t2_alloc_17", 32'(alloc_idx), 32'd0);
    check_output("t2_ignored_busy", 32'(q1_busy), 32'd1);
    apply_cdb(4'd0, 32'h100, 32'd0);
    check_output("t2_full_pre", 32'(full), 32'd1);
    tick();
    check_output("t2_c_en", 32'(commit_en), 32'd1);
    check_output("t2_c_idx", 32'(commit_idx), 32'd0);
    check_output("t2_c_dest", 32'(commit_dest), 32'd1);
    check_output("t2_c_val", commit_val, 32'h100);
    check_output("t2_not_full", 32'(full), 32'd0);

    // Mispredicted branch at head flushes; same-cycle issue and CDB are dropped
    apply_reset();
    apply_issue(5'd0, 1'b1, 32'h104, 1'b0, 32'd0);
    apply_issue(5'd5, 1'b0, 32'd0, 1'b1, 32'd7);
    apply_cdb(4'd0, 32'd0, 32'h200);
    issue_en = 1'b1;
    issue_dest = 5'd9;
    cdb_en = 1'b1;
    cdb_idx = 4'd1;
    cdb_val = 32'h99;
    tick();
    issue_en = 1'b0;
    cdb_en = 1'b0;
    q1_idx = 4'd1;
    #1;
    check_output("t3_rb", 32'(roll_back), 32'd1);
    check_output("t3_rb_pc", roll_back_pc, 32'h200);
    check_output("t3_no_commit", 32'(commit_en), 32'd0);
    check_output("t3_alloc", 32'(alloc_idx), 32'd0);
    check_output("t3_cdb_dropped", q1_val, 32'd7);
    tick();
    check_output("t3_rb_pulse", 32'(roll_back), 32'd0);
    check_output("t3_flushed", 32'(commit_en), 32'd0);
    apply_issue(5'd0, 1'b1, 32'h300, 1'b0, 32'd0);
    apply_cdb(4'd0, 32'd5, 32'h300);
    tick();
    check_output("t3_br_commit", 32'(commit_en), 32'd1);
    check_output("t3_br_dest", 32'(commit_dest), 32'd0);
    check_output("t3_br_val", commit_val, 32'd5);
    check_output("t3_br_no_rb", 32'(roll_back), 32'd0);

    // Operand query racing a CDB write
    apply_reset();
    for (int i = 0; i < 6; i++) apply_issue(5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
    q1_idx = 4'd5;
    q2_idx = 4'd4;
    cdb_en = 1'b1;
    cdb_idx = 4'd5;
    cdb_val = 32'hABCD;
    cdb_next_pc = 32'd0;
    #1;
`ifdef ROB_CDB_FWD_EN
    check_output("t4_fwd_busy", 32'(q1_busy), 32'd0);
    check_output("t4_fwd_val", q1_val, 32'hABCD);
`else
    check_output("t4_nofwd_busy", 32'(q1_busy), 32'd1);
`endif
    check_output("t4_q2_busy", 32'(q2_busy), 32'd1);
    tick();
    cdb_en = 1'b0;
    #1;
    check_output("t4_next_busy", 32'(q1_busy), 32'd0);
    check_output("t4_next_val", q1_val, 32'hABCD);

    // Stream of 40 ready instructions wraps both pointers
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      issue_en = 1'b1;
      issue_dest = 5'((i % 31) + 1);
      issue_is_br = 1'b0;
      issue_ready = 1'b1;
      issue_val = 32'h1000 + 32'(i);
      tick();
      if (commit_en) begin
        check_output("t5_idx", 32'(commit_idx), 32'(n_commits % 16));
        check_output("t5_val", commit_val, 32'h1000 + 32'(n_commits));
        check_output("t5_dest", 32'(commit_dest), 32'((n_commits % 31) + 1));
        n_commits++;
      end
    end
    issue_en = 1'b0;
    issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (commit_en) begin
        check_output("t5_idx", 32'(commit_idx), 32'(n_commits % 16));
        check_output("t5_val", commit_val, 32'h1000 + 32'(n_commits));
        n_commits++;
      end
    end
    check_output("t5_total", 32'(n_commits), 32'd40);
    check_output("t5_alloc_wrap", 32'(alloc_idx), 32'd8);

    // Stall with a ready head, then async reset mid-stream
    apply_reset();
    apply_issue(5'd3, 1'b0, 32'd0, 1'b1, 32'h55);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("t6_stall", 32'(commit_en), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check_output("t6_c_en", 32'(commit_en), 32'd1);
    check_output("t6_c_val", commit_val, 32'h55);
    rst_in = 1'b0;
    #1;
    check_output("t6_rst_en", 32'(commit_en), 32'd0);
    check_output("t6_rst_val", commit_val, 32'd0);
    check_output("t6_rst_dest", 32'(commit_dest), 32'd0);
    check_output("t6_rst_alloc", 32'(alloc_idx), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
